spi_cmd_master: RTL and testbench

SPI_CMD_MASTER -- requirements
Module: spi_cmd_master

---
 rtl/spi_cmd_master.sv | 204 ++++++++++++++++++++
 tb/tb_spi_cmd_master.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master: sends 0-3 bytes of a 24-bit command, each byte in its own
// cs_n window, and returns the last byte clocked in on miso.
module spi_cmd_master #(
    parameter int HALF_DIV = 2,
    parameter int CS_SETUP = 5,
    parameter int CS_HOLD  = 5,
    parameter int GAP      = 5
) (
    input  logic        clk_in,
    input  logic        sys_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_data,
    input  logic [1:0]  cmd_len,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        done,
    output logic [2:0]  dbg_state
);

    localparam int T_MAX  = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > GAP) ? CS_SETUP : GAP)
                                                 : ((CS_HOLD > GAP) ? CS_HOLD : GAP);
    localparam int CNT_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int DIV_W  = $clog2(HALF_DIV + 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP - 1);
    localparam logic [DIV_W-1:0] DIV_LD   = DIV_W'(HALF_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [1:0]       len_q, len_d;
    logic [23:0]      data_q, data_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;
    logic             rx_valid_q, rx_valid_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic [7:0]       cur_byte;
    logic             last_byte;

    // Handshake: a frame transfers on a rising edge where cmd_valid && cmd_ready; cmd_ready
    // is high only in IDLE, so once accepted the inputs are ignored until done pulses.
    always_comb begin
        cur_byte = data_q[7:0];
        case (byte_q)
            2'd0:    cur_byte = data_q[23:16];
            2'd1:    cur_byte = data_q[15:8];
            default: cur_byte = data_q[7:0];
        endcase
        last_byte = (len_q == 2'd0) || (byte_q == len_q - 2'd1);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        len_d      = len_q;
        data_d     = data_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    data_d = cmd_data;
                    len_d  = cmd_len;
                    byte_d = 2'd0;
                    // An empty frame passes through a one-cycle GAP with cs_n still high.
                    if (cmd_len == 2'd0) begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_SETUP;
                        cs_n_d  = 1'b0;
                        sclk_d  = 1'b0;
                        cnt_d   = SETUP_LD;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_SHIFT;
                    bit_d   = 3'd7;
                    div_d   = DIV_LD;
                    sclk_d  = 1'b0;
                    mosi_d  = cur_byte[7];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - 1'b1;
                end else begin
                    div_d = DIV_LD;
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        rx_sh_d = {rx_sh_q[6:0], miso};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 3'd0) begin
                            state_d    = S_HOLD;
                            cnt_d      = HOLD_LD;
                            rx_data_d  = rx_sh_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            bit_d  = bit_q - 3'd1;
                            mosi_d = cur_byte[bit_q - 3'd1];
                        end
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cs_n_d  = 1'b1;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (last_byte) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    byte_d  = byte_q + 2'd1;
                    state_d = S_SETUP;
                    cs_n_d  = 1'b0;
                    cnt_d   = SETUP_LD;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            bit_q      <= 3'd0;
            byte_q     <= 2'd0;
            len_q      <= 2'd0;
            data_q     <= 24'h0;
            rx_sh_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            len_q      <= len_d;
            data_q     <= data_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign sclk      = sclk_q;
    assign cs_n      = cs_n_q;
    assign mosi      = mosi_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: per-cycle timeline model derived from byte timing arithmetic,
// a mode-0 slave on miso, and literal checks on captured bytes and latencies.
module tb_spi_cmd_master;

    localparam int HD  = 2;
    localparam int SU  = 5;
    localparam int HO  = 5;
    localparam int GP  = 5;
    localparam int PER = SU + 16 * HD + HO + GP;

    logic        clk;
    logic        sys_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_data;
    logic [1:0]  cmd_len;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        done;
    logic [2:0]  dbg_state;

    spi_cmd_master #(.HALF_DIV(HD), .CS_SETUP(SU), .CS_HOLD(HO), .GAP(GP)) dut (
        .clk_in(clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_len(cmd_len), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid), .done(done),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    // {stamp[31:0], check_mosi, ready, cs_n, sclk, mosi, rx_valid, rx_data[7:0], done}
    logic [46:0] exp_q[$];
    logic [7:0]  model_rx = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [46:0] mk(input int stamp, input logic cm, input logic rdy,
                                       input logic cs, input logic sc, input logic mo,
                                       input logic rv, input logic [7:0] rd, input logic dn);
        return {32'(stamp), cm, rdy, cs, sc, mo, rv, rd, dn};
    endfunction

    // Timeline of one frame from its byte timing: setup, 8 bits of low/high halves, hold, gap.
    task automatic model_frame(input int s, input logic [23:0] d, input logic [1:0] len,
                               input logic [7:0] sb);
        logic [7:0] byt;
        int u;
        int k;
        if (len == 2'd0) begin
            exp_q.push_back(mk(s, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, model_rx, 1'b0));
            exp_q.push_back(mk(s + 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, model_rx, 1'b1));
            return;
        end
        for (int b = 0; b < int'(len); b++) begin
            byt = 8'(d >> (8 * (2 - b)));
            for (int t = 0; t < PER; t++) begin
                if (t < SU) begin
                    exp_q.push_back(mk(s + b * PER + t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                       model_rx, 1'b0));
                end else if (t < SU + 16 * HD) begin
                    u = t - SU;
                    k = u / (2 * HD);
                    exp_q.push_back(mk(s + b * PER + t, 1'b1, 1'b0, 1'b0, (u % (2 * HD)) >= HD,
                                       byt[7 - k], 1'b0, model_rx, 1'b0));
                end else if (t < SU + 16 * HD + HO) begin
                    if (t == SU + 16 * HD) model_rx = sb;
                    exp_q.push_back(mk(s + b * PER + t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                       t == SU + 16 * HD, model_rx, 1'b0));
                end else begin
                    exp_q.push_back(mk(s + b * PER + t, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                       model_rx, 1'b0));
                end
            end
        end
        exp_q.push_back(mk(s + int'(len) * PER, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                           model_rx, 1'b1));
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [46:0] e;
        logic [12:0] obs;
        logic [12:0] req;
        if (exp_q.size() > 0 && exp_q[0][46:15] == 32'(cyc)) begin
            e   = exp_q.pop_front();
            obs = {cmd_ready, cs_n, sclk, mosi & e[14], rx_valid, rx_data, done};
            req = {e[13], e[12], e[11], e[10] & e[14], e[9], e[8:1], e[0]};
            n_tests++;
            if (obs !== req) begin
                n_fail++;
                $display("FAIL cycle_cmp @%0d: got rdy=%b cs_n=%b sclk=%b mosi=%b rv=%b rx=%h done=%b, expected rdy=%b cs_n=%b sclk=%b mosi=%b rv=%b rx=%h done=%b",
                         cyc, obs[12], obs[11], obs[10], obs[9], obs[8], obs[7:0], obs[0],
                         req[12], req[11], req[10], req[9], req[8], req[7:0], req[0]);
            end
        end
    end

    // ---------------- mode-0 slave: next bit on each sclk fall ----------------
    logic [7:0] slave_byte = 8'h00;
    int         s_rises = 0;
    logic       s_prev = 1'b0;
    always @(negedge clk) begin
        if (cs_n) begin
            s_rises = 0;
            miso = slave_byte[7];
        end else begin
            if (sclk && !s_prev) s_rises++;
            if (!sclk && s_prev && s_rises < 8) miso = slave_byte[7 - s_rises];
        end
        s_prev = sclk;
    end

    // ---------------- bus monitor ----------------
    logic [7:0] mon_byte = 8'h00;
    logic [7:0] mon_bytes[$];
    int         mon_rises[$];
    logic [7:0] mon_rx[$];
    int         done_cyc[$];
    int         win_cnt = 0;
    int         rise_total = 0;
    int         rises_in_win = 0;
    logic       cs_prev = 1'b1;
    logic       sc_prev = 1'b0;
    always @(negedge clk) begin
        if (!sys_rst) begin
            if (!cs_n && cs_prev) begin
                win_cnt++;
                rises_in_win = 0;
            end
            if (sclk && !sc_prev) begin
                rise_total++;
                rises_in_win++;
                mon_byte = {mon_byte[6:0], mosi};
            end
            if (cs_n && !cs_prev) begin
                mon_bytes.push_back(mon_byte);
                mon_rises.push_back(rises_in_win);
            end
            if (done) done_cyc.push_back(cyc);
            if (rx_valid) mon_rx.push_back(rx_data);
        end
        cs_prev = cs_n;
        sc_prev = sclk;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        mon_bytes.delete();
        mon_rises.delete();
        mon_rx.delete();
        done_cyc.delete();
        win_cnt = 0;
        rise_total = 0;
    endtask

    task automatic start_frame(input logic [23:0] d, input logic [1:0] len,
                               input logic [7:0] sb, output int s);
        @(posedge clk);
        #1;
        check("ready_before_accept", 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_data   = d;
        cmd_len    = len;
        slave_byte = sb;
        s = cyc + 1;
        model_frame(s, d, len, sb);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int s;
        sys_rst   = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 24'h0;
        cmd_len   = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        sys_rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_release", 32'(cmd_ready), 32'd1);

        // three-byte frame
        clear_mon();
        start_frame(24'h916400, 2'd3, 8'h3C, s);
        wait_to(s);
        cmd_valid = 1'b0;
        cmd_data  = 24'hFFFFFF;
        wait_to(s + 3 * PER + 4);
        check("f3_windows", 32'(win_cnt), 32'd3);
        check("f3_byte0", 32'(mon_bytes.size() > 0 ? mon_bytes[0] : 8'hxx), 32'h91);
        check("f3_byte1", 32'(mon_bytes.size() > 1 ? mon_bytes[1] : 8'hxx), 32'h64);
        check("f3_byte2", 32'(mon_bytes.size() > 2 ? mon_bytes[2] : 8'hxx), 32'h00);
        check("f3_rises", 32'(rise_total), 32'd24);
        for (int i = 0; i < mon_rises.size(); i++) check("f3_rises_win", 32'(mon_rises[i]), 32'd8);
        check("f3_done_lat", 32'(done_cyc.size() > 0 ? done_cyc[0] - s : -1), 32'd141);
        check("f3_rx_count", 32'(mon_rx.size()), 32'd3);

        // one-byte frame with slave returning 0xA5
        clear_mon();
        start_frame(24'h060000, 2'd1, 8'hA5, s);
        wait_to(s);
        cmd_valid = 1'b0;
        wait_to(s + PER + 4);
        check("f1_windows", 32'(win_cnt), 32'd1);
        check("f1_byte0", 32'(mon_bytes.size() > 0 ? mon_bytes[0] : 8'hxx), 32'h06);
        check("f1_done_lat", 32'(done_cyc.size() > 0 ? done_cyc[0] - s : -1), 32'd47);
        check("f1_rx", 32'(mon_rx.size() == 1 ? mon_rx[0] : 8'hxx), 32'hA5);
        check("f1_cs_high_after", 32'(cs_n), 32'd1);

        // empty frame
        clear_mon();
        start_frame(24'hFFFFFF, 2'd0, 8'h00, s);
        wait_to(s);
        cmd_valid = 1'b0;
        wait_to(s + 6);
        check("f0_done_lat", 32'(done_cyc.size() > 0 ? done_cyc[0] - s : -1), 32'd1);
        check("f0_windows", 32'(win_cnt), 32'd0);
        check("f0_rises", 32'(rise_total), 32'd0);

        // valid held across two frames; data changed mid-frame must not leak into frame A
        clear_mon();
        start_frame(24'hABCDEF, 2'd2, 8'h5A, s);
        wait_to(s);
        cmd_data = 24'h123456;
        cmd_len  = 2'd1;
        model_frame(s + 2 * PER + 1, 24'h123456, 2'd1, 8'h5A);
        wait_to(s + 2 * PER + 1);
        cmd_valid = 1'b0;
        wait_to(s + 3 * PER + 6);
        check("b2b_windows", 32'(win_cnt), 32'd3);
        check("b2b_byte0", 32'(mon_bytes.size() > 0 ? mon_bytes[0] : 8'hxx), 32'hAB);
        check("b2b_byte1", 32'(mon_bytes.size() > 1 ? mon_bytes[1] : 8'hxx), 32'hCD);
        check("b2b_byte2", 32'(mon_bytes.size() > 2 ? mon_bytes[2] : 8'hxx), 32'h12);
        check("b2b_done_spacing",
              32'(done_cyc.size() == 2 ? done_cyc[1] - done_cyc[0] : -1), 32'd48);

        // reset at the 4th sclk rise of byte1
        clear_mon();
        start_frame(24'h916400, 2'd3, 8'hFF, s);
        wait_to(s);
        cmd_valid = 1'b0;
        wait_to(s + PER + SU + 3 * 2 * HD + HD);
        check("rst_at_rise4_sclk", 32'(sclk), 32'd1);
        sys_rst = 1'b1;
        while (exp_q.size() > 0 && int'(exp_q[$][46:15]) > cyc) void'(exp_q.pop_back());
        for (int i = 1; i <= 3; i++)
            exp_q.push_back(mk(cyc + i, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
        for (int i = 4; i <= 14; i++)
            exp_q.push_back(mk(cyc + i, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
        model_rx = 8'h00;
        wait_to(cyc + 3);
        sys_rst = 1'b0;
        wait_to(cyc + 13);
        check("rst_mid_no_done", 32'(done_cyc.size()), 32'd0);
        check("rst_mid_rx_count", 32'(mon_rx.size()), 32'd1);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);

        // recovery frame
        clear_mon();
        start_frame(24'h5A0000, 2'd1, 8'h81, s);
        wait_to(s);
        cmd_valid = 1'b0;
        wait_to(s + PER + 4);
        check("rec_byte0", 32'(mon_bytes.size() > 0 ? mon_bytes[0] : 8'hxx), 32'h5A);
        check("rec_rx", 32'(mon_rx.size() == 1 ? mon_rx[0] : 8'hxx), 32'h81);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
